// File: rtl/clock_cfg_ctrl.sv
// Keypad configuration controller for the BCD wall clock: direct HHMM time load,
// multi-slot alarm programming, ring with auto-stop, entry timeout and tick enable.
module clock_cfg_ctrl #(
  parameter int unsigned NUM_ALARMS     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 270000000,
  parameter int unsigned RING_SECONDS   = 60
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_valid,
  input  logic [3:0]              key_code,
  input  logic                    sec_tick,
  input  logic [7:0]              cur_hour,
  input  logic [7:0]              cur_minute,
  input  logic [7:0]              cur_second,
  output logic                    load_time,
  output logic [7:0]              load_hour,
  output logic [7:0]              load_minute,
  output logic [8*NUM_ALARMS-1:0] alarm_hour,
  output logic [8*NUM_ALARMS-1:0] alarm_minute,
  output logic [NUM_ALARMS-1:0]   alarm_valid,
  output logic                    ring,
  output logic [3:0]              ring_idx,
  output logic                    tick_en,
  output logic                    entry_err,
  output logic                    timeout,
  output logic [3:0]              state
);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned RING_W = $clog2(RING_SECONDS + 1);

  localparam logic [3:0] K_CANCEL = 4'd10;
  localparam logic [3:0] K_SET_T  = 4'd11;
  localparam logic [3:0] K_ACK    = 4'd12;
  localparam logic [3:0] K_SET_A  = 4'd13;
  localparam logic [3:0] K_CLR_A  = 4'd14;
  localparam logic [3:0] K_TICK   = 4'd15;

  typedef enum logic [3:0] {
    IDLE  = 4'd0, T_H1 = 4'd1, T_H0 = 4'd2, T_M1 = 4'd3, T_M0 = 4'd4,
    A_IDX = 4'd5, A_H1 = 4'd6, A_H0 = 4'd7, A_M1 = 4'd8, A_M0 = 4'd9,
    D_IDX = 4'd10
  } state_e;

  state_e                  state_q, state_d;
  logic [15:0]             stage_q, stage_d;
  logic [3:0]              slot_q, slot_d;
  logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
  logic [RING_W-1:0]       ring_cnt_q, ring_cnt_d;
  logic [7:0]              load_hour_d, load_minute_d;
  logic [8*NUM_ALARMS-1:0] alarm_hour_d, alarm_minute_d;
  logic [NUM_ALARMS-1:0]   alarm_valid_d;
  logic                    ring_d, tick_en_d, load_time_d, entry_err_d, timeout_d;
  logic [3:0]              ring_idx_d;

  logic       in_entry, is_digit, is_cancel, idle_key, digit_ok, digit_acc, digit_rej;
  logic       to_expire, match_any, trigger;
  logic [3:0] match_idx;

  assign state     = state_q;
  assign in_entry  = (state_q != IDLE);
  assign is_digit  = key_valid && (key_code <= 4'd9);
  assign is_cancel = key_valid && (key_code == K_CANCEL);
  assign idle_key  = key_valid && !in_entry;
  assign digit_acc = in_entry && is_digit && digit_ok;
  assign digit_rej = in_entry && is_digit && !digit_ok;
  assign to_expire = in_entry && !key_valid && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign trigger   = sec_tick && (cur_second == 8'h00) && match_any;

  // Range check of the digit for the field the current state is collecting
  always_comb begin
    digit_ok = 1'b0;
    case (state_q)
      T_H1, A_H1:   digit_ok = (key_code <= 4'd2);
      T_H0, A_H0:   digit_ok = (stage_q[15:12] == 4'd2) ? (key_code <= 4'd3) : 1'b1;
      T_M1, A_M1:   digit_ok = (key_code <= 4'd5);
      T_M0, A_M0:   digit_ok = 1'b1;
      A_IDX, D_IDX: digit_ok = (32'(key_code) < NUM_ALARMS);
      default:      digit_ok = 1'b0;
    endcase
  end

  // Lowest armed slot matching the current hour/minute
  always_comb begin
    match_any = 1'b0;
    match_idx = 4'd0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (alarm_valid[i] && (alarm_hour[8*i +: 8] == cur_hour) &&
          (alarm_minute[8*i +: 8] == cur_minute)) begin
        match_any = 1'b1;
        match_idx = 4'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!in_entry) begin
      if (key_valid) begin
        case (key_code)
          K_SET_T: state_d = T_H1;
          K_SET_A: state_d = A_IDX;
          K_CLR_A: state_d = D_IDX;
          default: state_d = IDLE;
        endcase
      end
    end else if (is_cancel || to_expire) begin
      state_d = IDLE;
    end else if (digit_acc) begin
      case (state_q)
        T_H1:    state_d = T_H0;
        T_H0:    state_d = T_M1;
        T_M1:    state_d = T_M0;
        A_IDX:   state_d = A_H1;
        A_H1:    state_d = A_H0;
        A_H0:    state_d = A_M1;
        A_M1:    state_d = A_M0;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    stage_d        = stage_q;
    slot_d         = slot_q;
    load_hour_d    = load_hour;
    load_minute_d  = load_minute;
    alarm_hour_d   = alarm_hour;
    alarm_minute_d = alarm_minute;
    alarm_valid_d  = alarm_valid;
    tick_en_d      = tick_en;
    load_time_d    = 1'b0;
    entry_err_d    = digit_rej;
    timeout_d      = to_expire;
    ring_d         = ring;
    ring_idx_d     = ring_idx;
    ring_cnt_d     = ring_cnt_q;

    if (!in_entry || key_valid || to_expire) to_cnt_d = '0;
    else                                     to_cnt_d = to_cnt_q + TO_W'(1);

    if (idle_key && (key_code == K_TICK)) tick_en_d = !tick_en;

    if (digit_acc) begin
      case (state_q)
        T_H1, A_H1: stage_d[15:12] = key_code;
        T_H0, A_H0: stage_d[11:8]  = key_code;
        T_M1, A_M1: stage_d[7:4]   = key_code;
        A_IDX:      slot_d         = key_code;
        T_M0: begin
          load_hour_d   = stage_q[15:8];
          load_minute_d = {stage_q[7:4], key_code};
          load_time_d   = 1'b1;
        end
        default: ;
      endcase
    end

    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (digit_acc && (state_q == A_M0) && (slot_q == 4'(i))) begin
        alarm_hour_d[8*i +: 8]   = stage_q[15:8];
        alarm_minute_d[8*i +: 8] = {stage_q[7:4], key_code};
        alarm_valid_d[i]         = 1'b1;
      end
      if (digit_acc && (state_q == D_IDX) && (key_code == 4'(i))) alarm_valid_d[i] = 1'b0;
    end

    // Stops first; a same-cycle trigger overrides them
    if (ring && sec_tick) begin
      if (ring_cnt_q == RING_W'(RING_SECONDS - 1)) begin
        ring_d     = 1'b0;
        ring_cnt_d = '0;
      end else begin
        ring_cnt_d = ring_cnt_q + RING_W'(1);
      end
    end
    if (idle_key && (key_code == K_ACK)) ring_d = 1'b0;
    if (digit_acc && (state_q == D_IDX) && ring && (key_code == ring_idx)) ring_d = 1'b0;
    if (trigger) begin
      ring_d     = 1'b1;
      ring_idx_d = match_idx;
      ring_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q      <= '0;
      slot_q       <= '0;
      to_cnt_q     <= '0;
      ring_cnt_q   <= '0;
      load_hour    <= '0;
      load_minute  <= '0;
      alarm_hour   <= '0;
      alarm_minute <= '0;
      alarm_valid  <= '0;
      tick_en      <= 1'b1;
      load_time    <= 1'b0;
      entry_err    <= 1'b0;
      timeout      <= 1'b0;
      ring         <= 1'b0;
      ring_idx     <= '0;
    end else begin
      stage_q      <= stage_d;
      slot_q       <= slot_d;
      to_cnt_q     <= to_cnt_d;
      ring_cnt_q   <= ring_cnt_d;
      load_hour    <= load_hour_d;
      load_minute  <= load_minute_d;
      alarm_hour   <= alarm_hour_d;
      alarm_minute <= alarm_minute_d;
      alarm_valid  <= alarm_valid_d;
      tick_en      <= tick_en_d;
      load_time    <= load_time_d;
      entry_err    <= entry_err_d;
      timeout      <= timeout_d;
      ring         <= ring_d;
      ring_idx     <= ring_idx_d;
    end
  end
endmodule
